// File: rtl/bus_hold_arbiter.sv
// Arbitrates the 8088 local bus between the CPU and two external masters (refresh, DMA)
// via hold/hlda. Optional per-grant watchdog enabled by defining ARB_WATCHDOG_EN.
module bus_hold_arbiter #(
    parameter int unsigned SETTLE_CYC = 2,
    parameter int unsigned DEAD_CYC   = 1,
    parameter int unsigned MAX_GRANT  = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    input  logic       hlda_i,
    output logic       hold_o,
    output logic [1:0] gnt_o,
    output logic       aen_o,
    output logic [1:0] owner_o,
    output logic       wd_err_o
);

    localparam int unsigned CntMax = (SETTLE_CYC > DEAD_CYC) ? SETTLE_CYC : DEAD_CYC;
    localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;
    localparam logic [CntW-1:0] SettleLast = CntW'(SETTLE_CYC - 1);
    localparam logic [CntW-1:0] DeadLast   = CntW'(DEAD_CYC - 1);

    if (SETTLE_CYC < 1 || DEAD_CYC < 1 || MAX_GRANT < 1) begin : g_bad_param
        $error("bus_hold_arbiter: SETTLE_CYC, DEAD_CYC and MAX_GRANT must be >= 1");
    end

    typedef enum logic [2:0] {
        StIdle,
        StHreq,
        StSettle,
        StGrant,
        StDead,
        StDrop
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            sel_q, sel_d;
    logic            chained_q, chained_d;
    logic            wd_hit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            sel_q     <= 1'b0;
            chained_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sel_q     <= sel_d;
            chained_q <= chained_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sel_d     = sel_q;
        chained_d = chained_q;
        unique case (state_q)
            StIdle: begin
                // A still-high hlda means the CPU has not yet taken the bus back.
                if ((req_i != 2'b00) && !hlda_i) begin
                    state_d = StHreq;
                end
            end
            StHreq: begin
                if (hlda_i) begin
                    state_d = StSettle;
                    cnt_d   = '0;
                end
            end
            StSettle: begin
                if (cnt_q == SettleLast) begin
                    cnt_d     = '0;
                    chained_d = 1'b0;
                    if (req_i[0]) begin
                        sel_d   = 1'b0;
                        state_d = StGrant;
                    end else if (req_i[1]) begin
                        sel_d   = 1'b1;
                        state_d = StGrant;
                    end else begin
                        state_d = StDrop;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StGrant: begin
                if (!req_i[sel_q] || wd_hit) begin
                    state_d = StDead;
                    cnt_d   = '0;
                end
            end
            StDead: begin
                if (cnt_q == DeadLast) begin
                    // Only the other requester may follow, and only once per hold.
                    if (!chained_q && req_i[~sel_q]) begin
                        sel_d     = ~sel_q;
                        chained_d = 1'b1;
                        state_d   = StGrant;
                    end else begin
                        state_d = StDrop;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDrop: begin
                if (!hlda_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

`ifdef ARB_WATCHDOG_EN
    localparam int unsigned WdW = (MAX_GRANT > 1) ? $clog2(MAX_GRANT) : 1;

    logic [WdW-1:0] wd_cnt_q, wd_cnt_d;
    logic           wd_err_q;

    assign wd_hit = (state_q == StGrant) && (wd_cnt_q == WdW'(MAX_GRANT - 1));

    // Held at zero outside GRANT so every grant starts a fresh count.
    always_comb begin
        wd_cnt_d = '0;
        if (state_q == StGrant) begin
            wd_cnt_d = wd_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_cnt_q <= '0;
            wd_err_q <= 1'b0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
            wd_err_q <= wd_hit;
        end
    end

    assign wd_err_o = wd_err_q;
`else
    assign wd_hit   = 1'b0;
    assign wd_err_o = 1'b0;
`endif

    always_comb begin
        hold_o = (state_q == StHreq) || (state_q == StSettle) ||
                 (state_q == StGrant) || (state_q == StDead);
        aen_o  = (state_q == StSettle) || (state_q == StGrant) || (state_q == StDead);
        gnt_o  = 2'b00;
        if (state_q == StGrant) begin
            gnt_o = sel_q ? 2'b10 : 2'b01;
        end
        owner_o = gnt_o;
    end

endmodule

// File: tb/tb_bus_hold_arbiter.sv
// Directed self-checking bench for bus_hold_arbiter; observed outputs are packed as
// {hold, aen, gnt, owner, wd_err} and compared against hand-derived constants.
module tb_bus_hold_arbiter;

    logic       clk  = 1'b0;
    logic       rst  = 1'b0;
    logic [1:0] req  = 2'b00;
    logic       hlda = 1'b0;
    logic       hold, aen, wd_err;
    logic [1:0] gnt, owner;

    int n_total = 0;
    int n_bad   = 0;

    localparam logic [6:0] OIdle = 7'b0_0_00_00_0;
    localparam logic [6:0] OHold = 7'b1_0_00_00_0;
    localparam logic [6:0] OAen  = 7'b1_1_00_00_0;
    localparam logic [6:0] ORef  = 7'b1_1_01_01_0;
    localparam logic [6:0] ODma  = 7'b1_1_10_10_0;
    localparam logic [6:0] OWd   = 7'b1_1_00_00_1;

    bus_hold_arbiter #(
        .SETTLE_CYC(2),
        .DEAD_CYC  (1),
        .MAX_GRANT (8)
    ) u_dut (
        .clk     (clk),
        .rst     (rst),
        .req_i   (req),
        .hlda_i  (hlda),
        .hold_o  (hold),
        .gnt_o   (gnt),
        .aen_o   (aen),
        .owner_o (owner),
        .wd_err_o(wd_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [6:0] got, input logic [6:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got {hold,aen,gnt,owner,wd}=%b expected %b", tag, got, exp);
        end
    endtask

    task automatic chk(input string tag, input logic [6:0] exp);
        check_eq(tag, {hold, aen, gnt, owner, wd_err}, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        #2;
        chk("reset_outputs", OIdle);
        step();
        step();
        rst = 1'b1;

        // IDLE must wait while hlda is still high
        hlda = 1'b1;
        req  = 2'b01;
        step(); chk("idle_hlda_high_a", OIdle);
        step(); chk("idle_hlda_high_b", OIdle);

        // Single refresh
        hlda = 1'b0;
        step(); chk("t1_hreq", OHold);
        step(); step(); chk("t1_hreq_wait", OHold);
        hlda = 1'b1;
        step(); chk("t1_settle_a", OAen);
        step(); chk("t1_settle_b", OAen);
        step(); chk("t1_grant", ORef);
        repeat (3) step();
        chk("t1_grant_held", ORef);
        req = 2'b00;
        step(); chk("t1_dead", OAen);
        step(); chk("t1_drop", OIdle);
        step(); chk("t1_drop_wait", OIdle);
        hlda = 1'b0;
        step(); chk("t1_idle", OIdle);

        // Simultaneous requests: refresh first, DMA chained
        req = 2'b11;
        step(); chk("t2_hreq", OHold);
        hlda = 1'b1;
        step(); step(); step(); chk("t2_ref_first", ORef);
        step(); chk("t2_dma_ignored", ORef);
        req = 2'b10;
        step(); chk("t2_dead", OAen);
        step(); chk("t2_chain_dma", ODma);
        step(); chk("t2_dma_held", ODma);
        req = 2'b00;
        step(); chk("t2_dead2", OAen);
        step(); chk("t2_drop", OIdle);
        hlda = 1'b0;
        step(); chk("t2_idle", OIdle);

        // Refresh re-requests in its own DEAD window: no second grant
        req = 2'b01;
        step(); chk("t3_hreq", OHold);
        hlda = 1'b1;
        step(); step(); step(); chk("t3_grant", ORef);
        req = 2'b00;
        step(); chk("t3_dead", OAen);
        req = 2'b01;
        step(); chk("t3_no_regrant", OIdle);
        step(); chk("t3_drop_wait", OIdle);
        hlda = 1'b0;
        step(); chk("t3_idle", OIdle);
        step(); chk("t3_new_hreq", OHold);
        hlda = 1'b1;
        step(); step(); step(); chk("t3_regrant", ORef);
        req = 2'b00;
        step(); step();
        hlda = 1'b0;
        step(); chk("t3_back_idle", OIdle);

        // Late hlda release with DMA pending
        req = 2'b10;
        step(); chk("t4_hreq", OHold);
        hlda = 1'b1;
        step(); step(); step(); chk("t4_grant", ODma);
        req = 2'b00;
        step(); chk("t4_dead", OAen);
        step(); chk("t4_drop", OIdle);
        req = 2'b10;
        for (int i = 0; i < 4; i++) begin
            step(); chk("t4_late_hlda", OIdle);
        end
        hlda = 1'b0;
        step(); chk("t4_idle", OIdle);
        step(); chk("t4_hreq_again", OHold);

        // Async reset mid-grant
        hlda = 1'b1;
        step(); step(); step(); chk("t5_grant", ODma);
        #3;
        rst = 1'b0;
        #1;
        chk("t5_async_rst", OIdle);
        hlda = 1'b0;
        step(); chk("t5_rst_held", OIdle);
        rst = 1'b1;
        step(); chk("t5_restart", OHold);
        hlda = 1'b1;
        step(); step(); step(); chk("t5_regrant", ODma);

        // DMA never releases
`ifdef ARB_WATCHDOG_EN
        for (int i = 0; i < 7; i++) begin
            step(); chk("t6_wd_gnt", ODma);
        end
        step(); chk("t6_wd_pulse", OWd);
        step(); chk("t6_wd_drop", OIdle);
`else
        repeat (20) step();
        chk("t6_unbounded", ODma);
`endif
        req  = 2'b00;
        hlda = 1'b0;
        repeat (4) step();
        chk("final_idle", OIdle);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
